// File: rtl/viterbi_decoder_pkg.sv
// Trellis constants and helpers for the K=3, rate-1/2 (7,5) convolutional code.
package viterbi_pkg;
  localparam int K = 3;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G0 = 3'b101;

  // The encoder shift register holds {u, u1, u2} where state = {u1, u2}.
  function automatic logic [1:0] exp_code(input logic [1:0] state, input logic u);
    logic [2:0] taps;
    taps = {u, state};
    return {^(taps & G1), ^(taps & G0)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] diff;
    diff = a ^ b;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction
endpackage

// File: rtl/viterbi_decoder_if.sv
// Symbol-in / decoded-bit-out bundle between the channel stage and the decoder.
interface viterbi_decoder_if;
  logic [1:0] code_sig;
  logic       code_valid_sig;
  logic       decode_sig;
  logic       decode_valid_sig;
  logic [1:0] err_inc_sig;

  modport master (
    output code_sig, code_valid_sig,
    input  decode_sig, decode_valid_sig, err_inc_sig
  );

  modport slave (
    input  code_sig, code_valid_sig,
    output decode_sig, decode_valid_sig, err_inc_sig
  );
endinterface

// File: rtl/viterbi_decoder_acs.sv
// Add-compare-select for one next state; ties resolve to the predecessor with s[0]=0.
module viterbi_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);
  localparam logic [PM_W-1:0] PM_MAX = '1;

  logic [PM_W:0]   sum0;
  logic [PM_W:0]   sum1;
  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  always_comb begin
    sum0   = {1'b0, pm0} + (PM_W + 1)'(bm0);
    sum1   = {1'b0, pm1} + (PM_W + 1)'(bm1);
    cand0  = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
    cand1  = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];
    dec    = (cand1 < cand0);
    pm_new = dec ? cand1 : cand0;
  end
endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder with register-exchange survivors and fixed decision delay.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6,
  parameter int PM_INIT  = 8
) (
  input logic             clk20M_sig,
  input logic             reset_sig,
  viterbi_decoder_if.slave bus
);
  localparam int FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

  logic [PM_W-1:0]       pm       [NUM_STATES];
  logic [PM_W-1:0]       pm_acs   [NUM_STATES];
  logic [PM_W-1:0]       pm_norm  [NUM_STATES];
  logic [NUM_STATES-1:0] dec;
  logic [TB_DEPTH-2:0]   surv     [NUM_STATES];
  logic [TB_DEPTH-1:0]   surv_new [NUM_STATES];
  logic [PM_W-1:0]       m;
  logic [1:0]            best;
  logic [FILL_W-1:0]     fill;

  // Only the low TB_DEPTH-1 survivor bits are stored; the oldest bit is consumed straight from surv_new.
  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
    localparam int   P0 = (ns % 2) * 2;
    localparam int   P1 = P0 + 1;
    localparam logic U  = (ns >= 2);

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = hamming2(bus.code_sig, exp_code(2'(P0), U));
    assign bm1 = hamming2(bus.code_sig, exp_code(2'(P1), U));

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0    (pm[P0]),
      .pm1    (pm[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_new (pm_acs[ns]),
      .dec    (dec[ns])
    );

    assign surv_new[ns] = {(dec[ns] ? surv[P1] : surv[P0]), U};
  end

  always_comb begin
    m = pm_acs[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (pm_acs[s] < m) m = pm_acs[s];
    end
    best = 2'd0;
    for (int s = NUM_STATES - 1; s >= 0; s--) begin
      if (pm_acs[s] == m) best = 2'(s);
    end
    for (int s = 0; s < NUM_STATES; s++) begin
      pm_norm[s] = pm_acs[s] - m;
    end
  end

  // Normalised metrics keep m within 0..2, so the clamp on err_inc_sig never engages.
  always_ff @(posedge clk20M_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      pm[0] <= '0;
      for (int s = 1; s < NUM_STATES; s++) pm[s] <= PM_W'(PM_INIT);
      for (int s = 0; s < NUM_STATES; s++) surv[s] <= '0;
      fill                 <= '0;
      bus.decode_sig       <= 1'b0;
      bus.decode_valid_sig <= 1'b0;
      bus.err_inc_sig      <= 2'd0;
    end else if (bus.code_valid_sig) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm[s]   <= pm_norm[s];
        surv[s] <= surv_new[s][TB_DEPTH-2:0];
      end
      if (fill != FILL_FULL) fill <= fill + 1'b1;
      bus.decode_sig       <= surv_new[best][TB_DEPTH-1];
      bus.err_inc_sig      <= (m > PM_W'(3)) ? 2'd3 : m[1:0];
      bus.decode_valid_sig <= (fill >= FILL_FULL - 1'b1);
    end else begin
      bus.decode_valid_sig <= 1'b0;
    end
  end
endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: directed streams plus a random channel
// checked against a cumulative-metric traceback reference decoder.
module tb_viterbi_decoder;
  localparam int TB_DEPTH = 16;
  localparam int PM_INIT  = 8;

  logic clk20M_sig;
  logic reset_sig;

  viterbi_decoder_if bus ();

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(6), .PM_INIT(PM_INIT)) dut (
    .clk20M_sig (clk20M_sig),
    .reset_sig  (reset_sig),
    .bus        (bus)
  );

  initial clk20M_sig = 1'b0;
  always #25 clk20M_sig = ~clk20M_sig;

  int errors;
  int checks;

  // Reference decoder: unbounded cumulative metrics and a full decision history.
  int         ref_pm [4];
  logic [3:0] ref_dec [$];
  int         ref_count;
  int         enc_state;

  function automatic logic [1:0] ref_code(input int state, input int u);
    int u1, u2;
    u1 = (state >> 1) & 1;
    u2 = state & 1;
    return {1'(u ^ u1 ^ u2), 1'(u ^ u2)};
  endfunction

  function automatic int ref_dist(input logic [1:0] a, input logic [1:0] b);
    return $countones(a ^ b);
  endfunction

  task automatic ref_reset();
    ref_pm[0] = 0;
    for (int s = 1; s < 4; s++) ref_pm[s] = PM_INIT;
    ref_dec.delete();
    ref_count = 0;
    enc_state = 0;
  endtask

  task automatic encode_bit(input int u, output logic [1:0] code);
    code      = ref_code(enc_state, u);
    enc_state = ((u & 1) << 1) | (enc_state >> 1);
  endtask

  task automatic ref_step(input logic [1:0] code, output logic exp_dv,
                          output logic exp_dec, output logic [1:0] exp_err);
    int nm [4];
    logic [3:0] d;
    int old_min, new_min, best, s, u, pa, pb, ca, cb;
    old_min = ref_pm[0];
    for (int i = 1; i < 4; i++) if (ref_pm[i] < old_min) old_min = ref_pm[i];
    for (int ns = 0; ns < 4; ns++) begin
      u  = ns >> 1;
      pa = (ns & 1) * 2;
      pb = pa + 1;
      ca = ref_pm[pa] + ref_dist(code, ref_code(pa, u));
      cb = ref_pm[pb] + ref_dist(code, ref_code(pb, u));
      d[ns]  = (cb < ca);
      nm[ns] = (cb < ca) ? cb : ca;
    end
    new_min = nm[0];
    for (int i = 1; i < 4; i++) if (nm[i] < new_min) new_min = nm[i];
    best = 0;
    for (int i = 3; i >= 0; i--) if (nm[i] == new_min) best = i;
    ref_dec.push_back(d);
    for (int i = 0; i < 4; i++) ref_pm[i] = nm[i];
    ref_count++;
    exp_err = 2'(new_min - old_min);
    exp_dv  = (ref_count >= TB_DEPTH);
    exp_dec = 1'b0;
    if (exp_dv) begin
      s = best;
      for (int t = ref_count - 1; t > ref_count - TB_DEPTH; t--)
        s = ((s & 1) << 1) | int'(ref_dec[t][s]);
      exp_dec = 1'((s >> 1) & 1);
    end
  endtask

  task automatic do_cycle(input logic [1:0] code, input logic valid,
                          output logic o_dec, output logic o_dv, output logic [1:0] o_err);
    bus.code_sig       = code;
    bus.code_valid_sig = valid;
    @(posedge clk20M_sig);
    #1;
    o_dec = bus.decode_sig;
    o_dv  = bus.decode_valid_sig;
    o_err = bus.err_inc_sig;
  endtask

  task automatic apply_reset();
    bus.code_valid_sig = 1'b0;
    bus.code_sig       = 2'b00;
    reset_sig          = 1'b0;
    repeat (2) @(posedge clk20M_sig);
    #1 reset_sig = 1'b1;
    ref_reset();
  endtask

  task automatic test_reset();
    bus.code_valid_sig = 1'b0;
    bus.code_sig       = 2'b00;
    reset_sig          = 1'b0;
    repeat (2) @(posedge clk20M_sig);
    #1;
    checks++; if (bus.decode_sig !== 1'b0) begin errors++; $display("[TB] FAIL reset_decode got=%0b exp=0", bus.decode_sig); end
    checks++; if (bus.decode_valid_sig !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.decode_valid_sig); end
    checks++; if (bus.err_inc_sig !== 2'd0) begin errors++; $display("[TB] FAIL reset_err got=%0d exp=0", bus.err_inc_sig); end
    reset_sig = 1'b1;
    ref_reset();
  endtask

  task automatic test_all_zero();
    logic o_dec, o_dv;
    logic [1:0] o_err;
    apply_reset();
    for (int n = 0; n < 64; n++) begin
      do_cycle(2'b00, 1'b1, o_dec, o_dv, o_err);
      checks++; if (o_dv !== (n >= TB_DEPTH - 1)) begin errors++; $display("[TB] FAIL zero_valid n=%0d got=%0b exp=%0b", n, o_dv, (n >= TB_DEPTH - 1)); end
      checks++; if (o_dec !== 1'b0) begin errors++; $display("[TB] FAIL zero_decode n=%0d got=%0b exp=0", n, o_dec); end
      checks++; if (o_err !== 2'd0) begin errors++; $display("[TB] FAIL zero_err n=%0d got=%0d exp=0", n, o_err); end
    end
  endtask

  // Info 1,0,1,1,0,0 then zeros; gap>1 inserts idle cycles carrying junk codes.
  task automatic test_known_stream(input bit flip, input int gap);
    logic [1:0] head [7];
    logic info [32];
    logic [1:0] code, o_err, exp_err, last_err;
    logic o_dec, o_dv, exp_dec, exp_dv, last_dec;
    int pulses;
    head = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 32; i++) info[i] = 1'b0;
    info[0] = 1'b1; info[2] = 1'b1; info[3] = 1'b1;
    apply_reset();
    last_dec = 1'b0;
    last_err = 2'd0;
    pulses   = 0;
    for (int n = 0; n < 32; n++) begin
      for (int g = 1; g < gap; g++) begin
        do_cycle(2'($urandom_range(0, 3)), 1'b0, o_dec, o_dv, o_err);
        if (o_dv === 1'b1) pulses++;
        checks++; if (o_dv !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid n=%0d got=%0b exp=0", n, o_dv); end
        checks++; if (o_dec !== last_dec) begin errors++; $display("[TB] FAIL idle_decode_hold n=%0d got=%0b exp=%0b", n, o_dec, last_dec); end
        checks++; if (o_err !== last_err) begin errors++; $display("[TB] FAIL idle_err_hold n=%0d got=%0d exp=%0d", n, o_err, last_err); end
      end
      code = (n < 7) ? head[n] : 2'b00;
      if (flip && n == 2) code = 2'b10;
      do_cycle(code, 1'b1, o_dec, o_dv, o_err);
      if (o_dv === 1'b1) pulses++;
      exp_dv  = (n >= TB_DEPTH - 1);
      exp_dec = 1'b0;
      if (exp_dv) exp_dec = info[n - TB_DEPTH + 1];
      exp_err = (flip && n == 2) ? 2'd1 : 2'd0;
      checks++; if (o_dv !== exp_dv) begin errors++; $display("[TB] FAIL known_valid n=%0d got=%0b exp=%0b", n, o_dv, exp_dv); end
      checks++; if (o_dec !== exp_dec) begin errors++; $display("[TB] FAIL known_decode n=%0d got=%0b exp=%0b", n, o_dec, exp_dec); end
      checks++; if (o_err !== exp_err) begin errors++; $display("[TB] FAIL known_err n=%0d got=%0d exp=%0d", n, o_err, exp_err); end
      last_dec = exp_dec;
      last_err = exp_err;
    end
    checks++; if (pulses != 32 - TB_DEPTH + 1) begin errors++; $display("[TB] FAIL known_pulse_count got=%0d exp=%0d", pulses, 32 - TB_DEPTH + 1); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] code, o_err, exp_err;
    logic o_dec, o_dv, exp_dec, exp_dv;
    apply_reset();
    for (int n = 0; n < 20; n++) begin
      encode_bit(int'($urandom_range(0, 1)), code);
      ref_step(code, exp_dv, exp_dec, exp_err);
      do_cycle(code, 1'b1, o_dec, o_dv, o_err);
      checks++; if (o_dv !== exp_dv) begin errors++; $display("[TB] FAIL mid_pre_valid n=%0d got=%0b exp=%0b", n, o_dv, exp_dv); end
      checks++; if (o_dec !== exp_dec) begin errors++; $display("[TB] FAIL mid_pre_decode n=%0d got=%0b exp=%0b", n, o_dec, exp_dec); end
    end
    #10 reset_sig = 1'b0;
    bus.code_valid_sig = 1'b0;
    #1;
    checks++; if (bus.decode_valid_sig !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_valid got=%0b exp=0", bus.decode_valid_sig); end
    checks++; if (bus.decode_sig !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_decode got=%0b exp=0", bus.decode_sig); end
    checks++; if (bus.err_inc_sig !== 2'd0) begin errors++; $display("[TB] FAIL mid_async_err got=%0d exp=0", bus.err_inc_sig); end
    @(posedge clk20M_sig);
    #1 reset_sig = 1'b1;
    ref_reset();
    for (int n = 0; n < 40; n++) begin
      encode_bit(int'($urandom_range(0, 1)), code);
      if (n % 9 == 4) code = code ^ 2'b01;
      ref_step(code, exp_dv, exp_dec, exp_err);
      do_cycle(code, 1'b1, o_dec, o_dv, o_err);
      checks++; if (o_dv !== exp_dv) begin errors++; $display("[TB] FAIL mid_post_valid n=%0d got=%0b exp=%0b", n, o_dv, exp_dv); end
      checks++; if (o_dec !== exp_dec) begin errors++; $display("[TB] FAIL mid_post_decode n=%0d got=%0b exp=%0b", n, o_dec, exp_dec); end
      checks++; if (o_err !== exp_err) begin errors++; $display("[TB] FAIL mid_post_err n=%0d got=%0d exp=%0d", n, o_err, exp_err); end
    end
  endtask

  // One channel error per 20 symbols; output must match both the model and the delayed info stream.
  task automatic test_random_long();
    logic [1:0] code, o_err, exp_err;
    logic o_dec, o_dv, exp_dec, exp_dv;
    logic info_hist [$];
    int u;
    apply_reset();
    for (int n = 0; n < 4000; n++) begin
      u = int'($urandom_range(0, 1));
      info_hist.push_back(1'(u));
      encode_bit(u, code);
      if (n % 20 == 7) code = code ^ (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      ref_step(code, exp_dv, exp_dec, exp_err);
      do_cycle(code, 1'b1, o_dec, o_dv, o_err);
      checks++; if (o_dv !== exp_dv) begin errors++; $display("[TB] FAIL long_valid n=%0d got=%0b exp=%0b", n, o_dv, exp_dv); end
      checks++; if (o_dec !== exp_dec) begin errors++; $display("[TB] FAIL long_decode n=%0d got=%0b exp=%0b", n, o_dec, exp_dec); end
      checks++; if (o_err !== exp_err) begin errors++; $display("[TB] FAIL long_err n=%0d got=%0d exp=%0d", n, o_err, exp_err); end
      if (n >= TB_DEPTH - 1) begin
        checks++;
        if (o_dec !== info_hist[n - TB_DEPTH + 1]) begin
          errors++;
          $display("[TB] FAIL long_info n=%0d got=%0b exp=%0b", n, o_dec, info_hist[n - TB_DEPTH + 1]);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.code_sig       = 2'b00;
    bus.code_valid_sig = 1'b0;
    reset_sig          = 1'b1;
    #5;
    $display("[TB] reset");
    test_reset();
    $display("[TB] all-zero stream");
    test_all_zero();
    $display("[TB] known stream");
    test_known_stream(1'b0, 1);
    $display("[TB] single channel error");
    test_known_stream(1'b1, 1);
    $display("[TB] gapped valid");
    test_known_stream(1'b0, 3);
    $display("[TB] reset mid-stream");
    test_reset_mid();
    $display("[TB] long random stream");
    test_random_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
